// File: rtl/hbhost_pkg.sv
// Shared definitions for the hexbus host initiator.
// Holds the protocol command characters, the transmit and receive state
// enums, and the nibble <-> lowercase-ASCII hex conversion helpers.
package hbhost_pkg;

    localparam logic [7:0] CH_A  = 8'h41;  // 'A' address
    localparam logic [7:0] CH_R  = 8'h52;  // 'R' read
    localparam logic [7:0] CH_W  = 8'h57;  // 'W' write
    localparam logic [7:0] CH_K  = 8'h4b;  // 'K' write ack
    localparam logic [7:0] CH_E  = 8'h45;  // 'E' error
    localparam logic [7:0] CH_I  = 8'h49;  // 'I' interrupt
    localparam logic [7:0] CH_Z  = 8'h5a;  // 'Z' idle
    localparam logic [7:0] CH_T  = 8'h54;  // 'T' reset notice
    localparam logic [7:0] CH_NL = 8'h0a;  // '\n'
    localparam logic [7:0] CH_CR = 8'h0d;  // '\r'

    typedef enum logic [2:0] {
        TX_IDLE, TX_ADDR, TX_CMD, TX_DATA, TX_NL, TX_WAIT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_NONE, RX_ADDR, RX_READ
    } rx_field_t;

    function automatic logic [7:0] nib_to_hex(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h57 + {4'h0, nib};   // 'a' - 10
    endfunction

    // Returns {valid, nibble}; valid only for '0'-'9' and 'a'-'f'.
    function automatic logic [4:0] hex_to_nib(input logic [7:0] ch);
        if (ch >= 8'h30 && ch <= 8'h39)
            return {1'b1, ch[3:0]};
        if (ch >= 8'h61 && ch <= 8'h66)
            return {1'b1, ch[3:0] + 4'd9};
        return 5'b0;
    endfunction

endpackage

// File: rtl/hbhostrx.sv
// Receive parser for hexbus response characters.
// Ports: i_clk, i_reset (sync, active-high), i_stb/i_byte incoming byte
// stream; o_rd_done/o_rd_data (read field terminated, accumulated value),
// o_wr_done ('K'), o_err_seen ('E'), o_int_seen ('I').
// The pulses are decoded in the same cycle as the incoming byte so the
// host can register its Wishbone response one cycle after sampling.
import hbhost_pkg::*;

module hbhostrx (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [7:0]  i_byte,
    output logic        o_rd_done,
    output logic [31:0] o_rd_data,
    output logic        o_wr_done,
    output logic        o_err_seen,
    output logic        o_int_seen
);

    rx_field_t   field;
    logic [31:0] acc;
    logic [4:0]  dec;
    logic        is_digit;

    assign dec       = hex_to_nib(i_byte);
    assign is_digit  = dec[4];
    assign o_rd_data = acc;

    always_comb begin
        o_rd_done  = i_stb && !is_digit && (field == RX_READ);
        o_wr_done  = i_stb && (i_byte == CH_K);
        o_err_seen = i_stb && (i_byte == CH_E);
        o_int_seen = i_stb && (i_byte == CH_I);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            field <= RX_NONE;
            acc   <= '0;
        end else if (i_stb) begin
            if (is_digit) begin
                if (field == RX_READ)
                    acc <= {acc[27:0], dec[3:0]};
            end else begin
                // Any non-digit closes the current field; only 'A' and 'R'
                // open a new one.
                case (i_byte)
                    CH_A: field <= RX_ADDR;
                    CH_R: begin
                        field <= RX_READ;
                        acc   <= '0;
                    end
                    default: field <= RX_NONE;
                endcase
            end
        end
    end

endmodule

// File: rtl/hbhost.sv
// Hexbus host initiator: Wishbone slave that serialises single-word
// requests into hexbus command lines and completes them from the parsed
// response stream.
// Ports: i_clk, i_reset (sync, active-high); Wishbone slave i_wb_cyc,
// i_wb_stb, i_wb_we, i_wb_addr[29:0], i_wb_data, i_wb_sel (unused),
// o_wb_stall, o_wb_ack, o_wb_err, o_wb_data; tx byte stream o_tx_stb,
// o_tx_byte, i_tx_busy; rx byte stream i_rx_stb, i_rx_byte; o_interrupt.
import hbhost_pkg::*;

module hbhost #(
    parameter int unsigned TIMEOUT = 32'd1 << 20
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [29:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [31:0] o_wb_data,
    output logic        o_tx_stb,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_busy,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_byte,
    output logic        o_interrupt
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    tx_state_t     state;
    logic [29:0]   req_addr, cached_addr;
    logic [31:0]   req_data, tx_shift;
    logic          req_we, cache_valid, abandoned;
    logic [3:0]    idx;
    logic [TW-1:0] timer;

    logic          rd_done, wr_done, err_seen, int_seen;
    logic [31:0]   rd_data;
    logic          tx_take, resp_ok, resp_bad, timed_out, gone;
    logic          unused_sel;

    assign unused_sel = ^i_wb_sel;
    assign o_wb_stall = (state != TX_IDLE);
    assign tx_take    = o_tx_stb && !i_tx_busy;
    assign gone       = abandoned || !i_wb_cyc;

    always_comb begin
        resp_ok   = (rd_done && !req_we) || (wr_done && req_we);
        resp_bad  = err_seen || (rd_done && req_we) || (wr_done && !req_we);
        timed_out = (timer == TW'(TIMEOUT - 1));
    end

    hbhostrx u_rx (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_stb      (i_rx_stb),
        .i_byte     (i_rx_byte),
        .o_rd_done  (rd_done),
        .o_rd_data  (rd_data),
        .o_wr_done  (wr_done),
        .o_err_seen (err_seen),
        .o_int_seen (int_seen)
    );

    // o_tx_byte always holds the byte currently offered; each consume
    // loads the following byte, so idx counts digits already offered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= TX_IDLE;
            req_addr    <= '0;
            req_data    <= '0;
            req_we      <= 1'b0;
            tx_shift    <= '0;
            idx         <= '0;
            timer       <= '0;
            cached_addr <= '0;
            cache_valid <= 1'b0;
            abandoned   <= 1'b0;
            o_wb_ack    <= 1'b0;
            o_wb_err    <= 1'b0;
            o_wb_data   <= '0;
            o_tx_stb    <= 1'b0;
            o_tx_byte   <= '0;
            o_interrupt <= 1'b0;
        end else begin
            o_wb_ack    <= 1'b0;
            o_wb_err    <= 1'b0;
            o_interrupt <= int_seen;

            case (state)
                TX_IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        req_addr  <= i_wb_addr;
                        req_data  <= i_wb_data;
                        req_we    <= i_wb_we;
                        abandoned <= 1'b0;
                        o_tx_stb  <= 1'b1;
                        if (cache_valid && (i_wb_addr == cached_addr)) begin
                            state     <= TX_CMD;
                            o_tx_byte <= i_wb_we ? CH_W : CH_R;
                        end else begin
                            state     <= TX_ADDR;
                            o_tx_byte <= CH_A;
                            idx       <= '0;
                            tx_shift  <= {i_wb_addr, 2'b00};
                        end
                    end
                end
                TX_ADDR: begin
                    if (tx_take) begin
                        if (idx == 4'd8) begin
                            state     <= TX_CMD;
                            o_tx_byte <= req_we ? CH_W : CH_R;
                        end else begin
                            o_tx_byte <= nib_to_hex(tx_shift[31:28]);
                            tx_shift  <= tx_shift << 4;
                            idx       <= idx + 4'd1;
                        end
                    end
                end
                TX_CMD: begin
                    if (tx_take) begin
                        if (req_we) begin
                            state     <= TX_DATA;
                            o_tx_byte <= nib_to_hex(req_data[31:28]);
                            tx_shift  <= req_data << 4;
                            idx       <= 4'd1;
                        end else begin
                            state     <= TX_NL;
                            o_tx_byte <= CH_NL;
                        end
                    end
                end
                TX_DATA: begin
                    if (tx_take) begin
                        if (idx == 4'd8) begin
                            state     <= TX_NL;
                            o_tx_byte <= CH_NL;
                        end else begin
                            o_tx_byte <= nib_to_hex(tx_shift[31:28]);
                            tx_shift  <= tx_shift << 4;
                            idx       <= idx + 4'd1;
                        end
                    end
                end
                TX_NL: begin
                    if (tx_take) begin
                        o_tx_stb <= 1'b0;
                        state    <= TX_WAIT;
                        timer    <= '0;
                    end
                end
                TX_WAIT: begin
                    timer <= timer + TW'(1);
                    if (resp_ok) begin
                        state <= TX_IDLE;
                        // The remote address advanced even if the master
                        // walked away, so the cache follows it regardless.
                        cached_addr <= req_addr + 30'd1;
                        cache_valid <= 1'b1;
                        if (!gone) begin
                            o_wb_ack <= 1'b1;
                            if (!req_we)
                                o_wb_data <= rd_data;
                        end
                    end else if (resp_bad || timed_out) begin
                        state       <= TX_IDLE;
                        cache_valid <= 1'b0;
                        if (!gone)
                            o_wb_err <= 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase

            if (state != TX_IDLE && !i_wb_cyc)
                abandoned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hbhost.sv
module tb_hbhost;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [29:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic        wb_stall, wb_ack, wb_err;
    logic [31:0] wb_rdata;
    logic        tx_stb, tx_busy = 1'b0;
    logic [7:0]  tx_byte;
    logic        rx_stb = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Bench-side model of the host's address cache.
    bit          m_valid = 1'b0;
    logic [29:0] m_addr = '0;

    logic [7:0]  txq[$];
    bit          busy_rand = 1'b0;
    bit          nl_seen = 1'b0;
    time         nl_time = 0;

    always #5 clk = ~clk;

    hbhost #(.TIMEOUT(64)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(4'hf),
        .o_wb_stall(wb_stall), .o_wb_ack(wb_ack), .o_wb_err(wb_err),
        .o_wb_data(wb_rdata),
        .o_tx_stb(tx_stb), .o_tx_byte(tx_byte), .i_tx_busy(tx_busy),
        .i_rx_stb(rx_stb), .i_rx_byte(rx_byte), .o_interrupt(irq)
    );

    // Link sink: chooses busy for the coming edge and logs consumed bytes.
    always @(negedge clk) begin
        tx_busy = busy_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (tx_stb && !tx_busy) begin
            txq.push_back(tx_byte);
            if (tx_byte == 8'h0a) begin
                nl_seen = 1'b1;
                nl_time = $time;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_str(input string name, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    // '\n' shown as '~' so that tx strings print on one line.
    function automatic string show(input logic [7:0] b);
        return (b == 8'h0a) ? "~" : $sformatf("%c", b);
    endfunction

    function automatic string hex8(input logic [31:0] v);
        return $sformatf("%08x", v);
    endfunction

    // kind: 0 = ack expected, 1 = err expected, 2 = timeout expected
    task automatic do_req(input string name, input bit we, input logic [29:0] addr,
                          input logic [31:0] data, input string rx, input bit busy,
                          input int kind, input logic [31:0] rdata,
                          input int term, input int int_at);
        string exp_tx, got_tx;
        int n_ack, n_err, n_int, ack_at, err_at, irq_at, stall_at_done;
        logic [31:0] got_data;
        bit done;

        exp_tx = (m_valid && m_addr == addr) ? "" : {"A", hex8({addr, 2'b00})};
        exp_tx = {exp_tx, we ? {"W", hex8(data)} : "R", "~"};

        @(negedge clk);
        chk({name, ".idle_stall"}, 32'(wb_stall), 32'd0);
        txq.delete();
        nl_seen   = 1'b0;
        busy_rand = busy;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = data;
        @(negedge clk);
        wb_stb = 1'b0;
        chk({name, ".first_byte_stb"}, {30'd0, tx_stb, wb_stall}, 32'd3);

        for (int i = 0; i < 400 && !nl_seen; i++) @(negedge clk);
        busy_rand = 1'b0;
        got_tx = "";
        foreach (txq[i]) got_tx = {got_tx, show(txq[i])};
        chk_str({name, ".tx"}, got_tx, exp_tx);

        n_ack = 0; n_err = 0; n_int = 0;
        ack_at = -1; err_at = -1; irq_at = -1; stall_at_done = -1;
        got_data = '0;
        if (kind == 2) begin
            done = 1'b0;
            for (int i = 0; i < 200 && !done; i++) begin
                @(negedge clk);
                if (wb_err) begin
                    done = 1'b1;
                    chk({name, ".timeout_cycles"}, 32'(($time - nl_time) / 10), 32'd65);
                    chk({name, ".timeout_stall"}, 32'(wb_stall), 32'd0);
                end
                if (wb_ack) n_ack++;
            end
            chk({name, ".timeout_seen"}, 32'(done), 32'd1);
            chk({name, ".timeout_no_ack"}, 32'(n_ack), 32'd0);
            @(negedge clk);
            chk({name, ".err_one_cycle"}, 32'(wb_err), 32'd0);
        end else begin
            for (int i = 0; i <= rx.len() + 1; i++) begin
                @(negedge clk);
                if (wb_ack) begin n_ack++; ack_at = i - 1; got_data = wb_rdata; stall_at_done = 32'(wb_stall); end
                if (wb_err) begin n_err++; err_at = i - 1; stall_at_done = 32'(wb_stall); end
                if (irq)    begin n_int++; irq_at = i - 1; end
                if (i < rx.len()) begin
                    rx_stb = 1'b1;
                    rx_byte = rx[i];
                end else begin
                    rx_stb = 1'b0;
                end
            end
            if (kind == 0) begin
                chk({name, ".ack_count"}, 32'(n_ack), 32'd1);
                chk({name, ".ack_pos"}, 32'(ack_at), 32'(term));
                chk({name, ".no_err"}, 32'(n_err), 32'd0);
                if (!we) chk({name, ".rdata"}, got_data, rdata);
            end else begin
                chk({name, ".err_count"}, 32'(n_err), 32'd1);
                chk({name, ".err_pos"}, 32'(err_at), 32'(term));
                chk({name, ".no_ack"}, 32'(n_ack), 32'd0);
            end
            chk({name, ".stall_on_done"}, 32'(stall_at_done), 32'd0);
            chk({name, ".irq_count"}, 32'(n_int), (int_at >= 0) ? 32'd1 : 32'd0);
            if (int_at >= 0) chk({name, ".irq_pos"}, 32'(irq_at), 32'(int_at));
        end
        wb_cyc = 1'b0;

        if (kind == 0) begin
            m_valid = 1'b1;
            m_addr  = addr + 30'd1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    typedef struct {
        bit          we;
        logic [29:0] addr;
        logic [31:0] data;
        logic [95:0] rx;      // right-aligned ASCII, leading zero bytes unused
        bit          busy;
        int          kind;
        logic [31:0] rdata;
        int          term;
        int          int_at;
    } vec_t;

    function automatic string rx_str(input logic [95:0] v);
        string s = "";
        bit started = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (v[8*i +: 8] != 8'h00) started = 1'b1;
            if (started) s = {s, $sformatf("%c", v[8*i +: 8])};
        end
        return s;
    endfunction

    vec_t tbl[10];

    initial begin
        string rx;
        logic [31:0] val, mask;
        logic [29:0] addr;
        bit we;
        int nd, term;

        tbl[0] = '{1'b1, 30'h4,        32'hdeadbeef, "A00000010\nK\n", 1'b0, 0, 32'h0,        10, -1};
        tbl[1] = '{1'b0, 30'h5,        32'h0,        "R12ab\n",        1'b0, 0, 32'h000012ab, 5,  -1};
        tbl[2] = '{1'b0, 30'h6,        32'h0,        "E\n",            1'b0, 1, 32'h0,        0,  -1};
        tbl[3] = '{1'b0, 30'h6,        32'h0,        "R1\n",           1'b0, 0, 32'h1,        2,  -1};
        tbl[4] = '{1'b1, 30'h7,        32'h01234567, "R5\n",           1'b1, 1, 32'h0,        2,  -1};
        tbl[5] = '{1'b0, 30'h3fffffff, 32'h0,        "K\n",            1'b0, 1, 32'h0,        0,  -1};
        tbl[6] = '{1'b1, 30'h3fffffff, 32'hcafef00d, "K\n",            1'b1, 0, 32'h0,        0,  -1};
        tbl[7] = '{1'b0, 30'h0,        32'h0,        "R123456789\n",   1'b0, 0, 32'h23456789, 10, -1};
        tbl[8] = '{1'b0, 30'h1,        32'h0,        "Rabc\r",         1'b0, 0, 32'h00000abc, 4,  -1};
        tbl[9] = '{1'b0, 30'h2,        32'h0,        "R12I34\n",       1'b0, 0, 32'h00000012, 3,  3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.outputs", {25'd0, wb_stall, wb_ack, wb_err, tx_stb, irq, 2'd0}, 32'd0);
        chk("reset.rdata", wb_rdata, 32'd0);
        chk("reset.txbyte", 32'(tx_byte), 32'd0);

        foreach (tbl[i])
            do_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].data,
                   rx_str(tbl[i].rx), tbl[i].busy, tbl[i].kind, tbl[i].rdata,
                   tbl[i].term, tbl[i].int_at);

        // Unsolicited interrupt while idle.
        @(negedge clk);
        rx_stb = 1'b1; rx_byte = 8'h49;
        @(negedge clk);
        rx_stb = 1'b0;
        chk("irq_idle.pulse", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_idle.one_cycle", 32'(irq), 32'd0);

        // No response at all.
        do_req("timeout", 1'b0, 30'h100, 32'h0, "", 1'b0, 2, 32'h0, 0, -1);

        // Randomised traffic with a busy link, half the time hitting the cache.
        for (int t = 0; t < 24; t++) begin
            we   = ($urandom_range(0, 1) == 1);
            addr = (m_valid && $urandom_range(0, 1) == 1) ? m_addr : 30'($urandom);
            val  = $urandom;
            term = 0;
            rx   = "";
            if (!(m_valid && m_addr == addr) && $urandom_range(0, 1) == 1) begin
                rx   = {"A", hex8({addr, 2'b00}), "\n"};
                term = 10;
            end
            if (we) begin
                rx = {rx, "K\n"};
                do_req($sformatf("rnd%0d", t), we, addr, val, rx, 1'b1, 0, 32'h0, term, -1);
            end else begin
                nd = $urandom_range(1, 8);
                rx = {rx, "R"};
                for (int k = nd - 1; k >= 0; k--) rx = {rx, $sformatf("%x", val[4*k +: 4])};
                rx = {rx, "\n"};
                mask = (nd == 8) ? 32'hffffffff : ((32'd1 << (4 * nd)) - 32'd1);
                do_req($sformatf("rnd%0d", t), we, addr, 32'h0, rx, 1'b1, 0, val & mask,
                       term + 1 + nd, -1);
            end
        end

        // Reset in the middle of the DATA field of a write to the cached address.
        addr = m_valid ? m_addr : 30'h55;
        @(negedge clk);
        txq.delete();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = addr; wb_wdata = 32'h89abcdef;
        @(negedge clk);
        wb_stb = 1'b0;
        for (int i = 0; i < 100 && txq.size() < 5; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset.outputs", {25'd0, wb_stall, wb_ack, wb_err, tx_stb, irq, 2'd0}, 32'd0);
        chk("midreset.rdata", wb_rdata, 32'd0);
        chk("midreset.txbyte", 32'(tx_byte), 32'd0);
        rst = 1'b0;
        wb_cyc = 1'b0;
        m_valid = 1'b0;
        do_req("post_reset", 1'b1, addr, 32'h13572468, "K\n", 1'b0, 0, 32'h0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
